pdatapath: RTL and testbench
============================

Name: pdatapath

Overview:
- Execution stage directly downstream of the serial packet controller.
- Consumes the controller's 3-bit opcode and the shared rx line.
- Holds two signed operands and a result accumulator; performs MUL and MUL_ADD.
- Serialises operands or result back onto tx as framed bits.

Parameters:
- DATA_W, 8, operand width (data1, data2).
- RES_W, 16, result/accumulator width; must be >= 2*DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- opcode  in  3  controller opcode: 0 OUT_DATA1, 1 OUT_DATA2, 2 OUT_RES, 3 LOAD, 4 LOAD_RES, 5 MUL, 6 MUL_ADD, 7 NO_OP
- rx  in  1  serial data, same line the controller samples
- tx  out  1  serial output, idle high
- busy  out  1  high while a tx frame or a load is in progress
- res  out  RES_W  current accumulator value

Behaviour:
- Reset (async, rst=1):
  - data1, data2 and res cleared to 0; opcode_q set to NO_OP.
  - tx=1, busy=0, load counter 0, tx FSM in IDLE.
- Entry detect: entry = (opcode != opcode_q); opcode_q is registered every cycle.
- LOAD:
  - On the entry cycle, the load counter is set to 2*DATA_W.
  - Each cycle while opcode==LOAD and counter>0: chain {data2,data1} <= {rx, chain[2*DATA_W-1:1]}; counter decrements.
  - Shifting stops at 0; any further held LOAD cycles are ignored.
  - Bit order: first rx bit ends in data1[0]; bit DATA_W ends in data2[0].
- LOAD_RES: same mechanism, RES_W bits shifted into res, LSB first.
- MUL:
  - On the entry cycle only: res <= sext(data1)*sext(data2), signed, sign-extended to RES_W.
  - Visible on res the next cycle.
- MUL_ADD:
  - On the entry cycle only: res <= res + sext(data1*data2).
  - Default arithmetic wraps modulo 2^RES_W.
- A held MUL/MUL_ADD (no new entry) never re-executes.
- tx FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on entry to any OUT_*. The source (data1, data2 or res) is snapshotted into the shift register; bit count = DATA_W, DATA_W or RES_W.
  - START: tx=0 for one cycle -> DATA.
  - DATA: tx = shreg[0], shift right once per cycle, LSB first; after the last bit -> STOP.
  - STOP: tx=1 for one cycle -> IDLE.
  - Abort: if opcode leaves the starting OUT_* before STOP completes, the next cycle is IDLE with tx=1 and no partial stop bit.
  - Re-entry: an OUT_* entry while not IDLE restarts the frame from START with a new snapshot.
- busy = (tx state != IDLE) or (load counter != 0).
- NO_OP and undefined transitions: no register changes except opcode_q.
- Reset mid-frame or mid-load: immediate return to reset values; the frame is not resumed.

Optional Feature:
- Macro: PDATAPATH_SAT_EN.
- Defined: MUL_ADD saturates to the signed RES_W range: overflow gives 0x7FFF, underflow gives 0x8000 (RES_W=16). Overflow is detected from the sign of res, the sign of the product, and the sign of the sum.
- Undefined: MUL_ADD wraps. No saturation logic is synthesised.

Decomposition:
- Shared package pdefs holds:
  - Opcode localparams (OUT_DATA1..NO_OP), also used by the controller.
  - Default DATA_W/RES_W.
  - tx FSM state encoding.
- One sub-module, ptx_ser: parameterised serialiser with the START/DATA/STOP FSM.
  - Inputs: load, abort, width, data.
  - Outputs: tx, active.
  - The datapath instantiates it once and muxes the snapshot source.

Test Plan:
- LOAD with rx stream data1=0x03, data2=0xFB (LSB first, 16 bits), then 16 extra held cycles -> data1=0x03, data2=0xFB (extra bits ignored); MUL -> res=0xFFF1 (-15) one cycle later.
- After the previous step, MUL_ADD held for 31 cycles -> res=0xFFE2 exactly once (no repeat accumulation).
- LOAD_RES 0x7FF0, LOAD data1=0x7F data2=0x7F, MUL_ADD -> res=0xBEF1 without PDATAPATH_SAT_EN; 0x7FFF with it.
- res=0xA5C3, OUT_RES held 127 cycles -> tx: 0, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, then idle high; busy high for exactly 18 cycles.
- OUT_DATA1 with data1=0x55, opcode switched to NO_OP after 4 frame cycles -> tx=1 next cycle, FSM IDLE, busy=0.
- rst pulse during an OUT_RES frame and during a LOAD -> tx=1, busy=0, data1=data2=res=0 immediately (async), no further shifting after release until a new entry.

Source files
------------

// File: rtl/pdefs.sv
// Shared definitions for the packet controller and its execution datapath:
// opcode encodings, default widths and the tx serialiser state encoding.
package pdefs;

  localparam logic [2:0] OUT_DATA1 = 3'd0;
  localparam logic [2:0] OUT_DATA2 = 3'd1;
  localparam logic [2:0] OUT_RES   = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] LOAD_RES  = 3'd4;
  localparam logic [2:0] MUL       = 3'd5;
  localparam logic [2:0] MUL_ADD   = 3'd6;
  localparam logic [2:0] NO_OP     = 3'd7;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_RES_W  = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ptx_ser.sv
// Framed serialiser: START (tx=0), DATA (width bits, LSB first), STOP (tx=1).
// load restarts a frame from a fresh snapshot; abort drops to IDLE with no stop bit.
module ptx_ser
  import pdefs::*;
#(
  parameter int MAX_W = DEF_RES_W,
  parameter int CW    = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             abort,
  input  logic [CW-1:0]    width,
  input  logic [MAX_W-1:0] data,
  output logic             tx,
  output logic             active
);

  tx_state_e        state_q, state_d;
  logic [MAX_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = TX_START;
      shreg_d = data;
      cnt_d   = width;
    end else if (abort) begin
      state_d = TX_IDLE;
    end else begin
      case (state_q)
        TX_START: state_d = TX_DATA;
        TX_DATA: begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_d = TX_STOP;
        end
        TX_STOP: state_d = TX_IDLE;
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx     = 1'b1;
    active = (state_q != TX_IDLE);
    case (state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shreg_q[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/pdatapath.sv
// Execution stage behind the serial packet controller: serial operand loads, signed
// MUL / MUL_ADD into the accumulator, framed tx readback. PDATAPATH_SAT_EN saturates MUL_ADD.
module pdatapath
  import pdefs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             rx,
  output logic             tx,
  output logic             busy,
  output logic [RES_W-1:0] res
);

  localparam int CW = $clog2(RES_W + 1);

  logic [2:0]        opcode_q;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [CW-1:0]     lcnt_q, lcnt_d;

  logic                     entry;
  logic [2*DATA_W-1:0]      chain;
  logic signed [RES_W-1:0]  op1_ext, op2_ext, prod_ext, sum, mac;

  assign entry = (opcode != opcode_q);
  assign chain = {data2_q, data1_q};

  // Product of two DATA_W operands always fits in RES_W, so the low RES_W bits are exact.
  assign op1_ext  = RES_W'($signed(data1_q));
  assign op2_ext  = RES_W'($signed(data2_q));
  assign prod_ext = op1_ext * op2_ext;
  assign sum      = $signed(res_q) + prod_ext;

`ifdef PDATAPATH_SAT_EN
  logic ovf, unf;
  assign ovf = ~res_q[RES_W-1] & ~prod_ext[RES_W-1] &  sum[RES_W-1];
  assign unf =  res_q[RES_W-1] &  prod_ext[RES_W-1] & ~sum[RES_W-1];
  assign mac = ovf ? {1'b0, {(RES_W-1){1'b1}}} :
               unf ? {1'b1, {(RES_W-1){1'b0}}} : sum;
`else
  assign mac = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= NO_OP;
      data1_q  <= '0;
      data2_q  <= '0;
      res_q    <= '0;
      lcnt_q   <= '0;
    end else begin
      opcode_q <= opcode;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      res_q    <= res_d;
      lcnt_q   <= lcnt_d;
    end
  end

  // Entry arms the load counter; shifting starts on the following cycle.
  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    res_d   = res_q;
    lcnt_d  = lcnt_q;
    case (opcode)
      LOAD: begin
        if (entry) begin
          lcnt_d = CW'(2 * DATA_W);
        end else if (lcnt_q != '0) begin
          {data2_d, data1_d} = {rx, chain[2*DATA_W-1:1]};
          lcnt_d             = lcnt_q - CW'(1);
        end
      end
      LOAD_RES: begin
        if (entry) begin
          lcnt_d = CW'(RES_W);
        end else if (lcnt_q != '0) begin
          res_d  = {rx, res_q[RES_W-1:1]};
          lcnt_d = lcnt_q - CW'(1);
        end
      end
      MUL:     if (entry) res_d = prod_ext;
      MUL_ADD: if (entry) res_d = mac;
      default: ;
    endcase
  end

  logic             tx_load, tx_abort, tx_active;
  logic [CW-1:0]    tx_width;
  logic [RES_W-1:0] tx_src;

  assign tx_load  = entry & (opcode inside {OUT_DATA1, OUT_DATA2, OUT_RES});
  assign tx_abort = entry & ~tx_load;

  always_comb begin
    tx_src   = res_q;
    tx_width = CW'(RES_W);
    case (opcode)
      OUT_DATA1: begin
        tx_src   = RES_W'(data1_q);
        tx_width = CW'(DATA_W);
      end
      OUT_DATA2: begin
        tx_src   = RES_W'(data2_q);
        tx_width = CW'(DATA_W);
      end
      default: ;
    endcase
  end

  ptx_ser #(
    .MAX_W (RES_W),
    .CW    (CW)
  ) u_ptx_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (tx_load),
    .abort  (tx_abort),
    .width  (tx_width),
    .data   (tx_src),
    .tx     (tx),
    .active (tx_active)
  );

  assign busy = tx_active | (lcnt_q != '0);
  assign res  = res_q;

endmodule

// File: tb/tb_pdatapath.sv
// Directed bench for pdatapath: table of arithmetic vectors plus hand-written
// sequences for framing, abort, re-entry and asynchronous reset.
module tb_pdatapath;
  import pdefs::*;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

`ifdef PDATAPATH_SAT_EN
  localparam logic [15:0] EXP_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_UNF = 16'h8000;
`else
  localparam logic [15:0] EXP_OVF = 16'hBEF1;
  localparam logic [15:0] EXP_UNF = 16'h4080;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       opcode;
  logic             rx;
  logic             tx;
  logic             busy;
  logic [RES_W-1:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  pdatapath #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .rx     (rx),
    .tx     (tx),
    .busy   (busy),
    .res    (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [15:0] r0;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_data(input logic [7:0] d1, input logic [7:0] d2,
                           input int extra, input logic [15:0] junk);
    logic [15:0] chain;
    chain  = {d2, d1};
    opcode = LOAD;
    rx     = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      rx = chain[i];
      tick();
    end
    for (int i = 0; i < extra; i++) begin
      rx = junk[i % 16];
      tick();
    end
    opcode = NO_OP;
    tick();
  endtask

  task automatic load_res(input logic [15:0] r);
    opcode = LOAD_RES;
    rx     = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      rx = r[i];
      tick();
    end
    opcode = NO_OP;
    tick();
  endtask

  // Enters op, samples the whole frame, then keeps op held for hold extra cycles.
  task automatic run_frame(input string name, input logic [2:0] op, input int w,
                           input logic [15:0] exp, input int hold);
    logic [15:0] val;
    int          busy_cnt;
    logic        idle_hi;
    val      = '0;
    busy_cnt = 0;
    idle_hi  = 1'b1;
    opcode   = op;
    tick();
    check({name, "_start"}, 32'(tx), 32'd0);
    if (busy) busy_cnt++;
    for (int i = 0; i < w; i++) begin
      tick();
      val[i] = tx;
      if (busy) busy_cnt++;
    end
    tick();
    check({name, "_stop"}, 32'(tx), 32'd1);
    if (busy) busy_cnt++;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (busy) busy_cnt++;
      idle_hi = idle_hi & tx;
    end
    check({name, "_data"}, 32'(val), 32'(exp));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(w + 2));
    check({name, "_idle_high"}, 32'(idle_hi), 32'd1);
    opcode = NO_OP;
    tick();
  endtask

  initial begin
    vecs[0] = '{MUL,     8'h03, 8'hFB, 16'h1234, 16'hFFF1};
    vecs[1] = '{MUL,     8'h80, 8'h80, 16'hFFFF, 16'h4000};
    vecs[2] = '{MUL,     8'h7F, 8'h80, 16'h0000, 16'hC080};
    vecs[3] = '{MUL_ADD, 8'h7F, 8'h7F, 16'h7FF0, EXP_OVF};
    vecs[4] = '{MUL_ADD, 8'h80, 8'h7F, 16'h8000, EXP_UNF};
    vecs[5] = '{MUL_ADD, 8'hFF, 8'h02, 16'h0010, 16'h000E};
    vecs[6] = '{MUL,     8'h00, 8'h5A, 16'hABCD, 16'h0000};
    vecs[7] = '{MUL_ADD, 8'h10, 8'h10, 16'h1234, 16'h1334};

    rst    = 1'b1;
    opcode = NO_OP;
    rx     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_res", 32'(res), 32'd0);
    rst = 1'b0;
    tick();

    // Load with 16 surplus held cycles of junk, which must be ignored.
    load_data(8'h03, 8'hFB, 16, 16'hA5A5);
    check("load_done_busy", 32'(busy), 32'd0);
    run_frame("out_d1", OUT_DATA1, 8, 16'h0003, 3);
    run_frame("out_d2", OUT_DATA2, 8, 16'h00FB, 3);
    opcode = MUL;
    tick();
    check("mul_next_cycle", 32'(res), 32'hFFF1);
    repeat (3) tick();
    opcode = MUL_ADD;
    tick();
    check("mac_first", 32'(res), 32'hFFE2);
    repeat (30) tick();
    check("mac_held_31", 32'(res), 32'hFFE2);
    opcode = NO_OP;
    tick();

    foreach (vecs[k]) begin
      load_res(vecs[k].r0);
      load_data(vecs[k].d1, vecs[k].d2, 0, 16'h0000);
      opcode = vecs[k].op;
      tick();
      opcode = NO_OP;
      tick();
      check($sformatf("vec%0d_res", k), 32'(res), 32'(vecs[k].exp_res));
    end

    load_res(16'hA5C3);
    check("load_res_val", 32'(res), 32'hA5C3);
    run_frame("out_res", OUT_RES, 16, 16'hA5C3, 109);
    check("out_res_unchanged", 32'(res), 32'hA5C3);

    // Abort after START plus three data bits of 0x55.
    load_data(8'h55, 8'h3C, 0, 16'h0000);
    opcode = OUT_DATA1;
    tick();
    tick();
    check("abort_bit0", 32'(tx), 32'd1);
    tick();
    tick();
    opcode = NO_OP;
    tick();
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("abort_stays_idle", 32'(tx), 32'd1);

    // Re-entry: switching OUT_DATA1 -> OUT_DATA2 mid-frame restarts with data2.
    opcode = OUT_DATA1;
    repeat (3) tick();
    run_frame("reentry_d2", OUT_DATA2, 8, 16'h003C, 2);

    // Async reset in the middle of an OUT_RES frame.
    load_res(16'hF00F);
    opcode = OUT_RES;
    repeat (5) tick();
    #2;
    opcode = NO_OP;
    rst    = 1'b1;
    #1;
    check("rst_frame_tx", 32'(tx), 32'd1);
    check("rst_frame_busy", 32'(busy), 32'd0);
    check("rst_frame_res", 32'(res), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_frame_after_tx", 32'(tx), 32'd1);

    // Async reset in the middle of LOAD_RES and LOAD.
    opcode = LOAD_RES;
    rx     = 1'b1;
    repeat (6) tick();
    check("mid_load_busy", 32'(busy), 32'd1);
    check("mid_load_res", 32'(res), 32'hF800);
    #2;
    opcode = NO_OP;
    rst    = 1'b1;
    #1;
    check("rst_load_res", 32'(res), 32'd0);
    check("rst_load_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_load_after_res", 32'(res), 32'd0);
    check("rst_load_after_busy", 32'(busy), 32'd0);

    load_data(8'hC3, 8'h96, 0, 16'h0000);
    opcode = LOAD;
    rx     = 1'b1;
    repeat (10) tick();
    #2;
    opcode = NO_OP;
    rst    = 1'b1;
    #1;
    check("rst_data_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    run_frame("rst_d1_cleared", OUT_DATA1, 8, 16'h0000, 1);
    run_frame("rst_d2_cleared", OUT_DATA2, 8, 16'h0000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
